// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with a pixel-FIFO read lead and delayed sync/blank/de/sof/eol.
// Optional underflow detection is compiled in with VTG_UNDERFLOW_EN.
module video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 11,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 31,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PIPE_LAT  = 2,
  parameter int   CNT_W     = 11
) (
  input  logic             pclk,
  input  logic             rstbtn_n,
  input  logic             restart,
  input  logic             fifo_empty,
  output logic             rd_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             sof,
  output logic             eol,
  output logic             underflow,
  output logic [15:0]      underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] HT1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VT1 = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HA  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HE  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             de;
    logic             hb;
    logic             vb;
    logic             hs;
    logic             vs;
    logic             sof;
    logic             eol;
  } px_t;
  localparam px_t BLANK = '{h: '0, v: '0, de: 1'b0, hb: 1'b1, vb: 1'b1,
                            hs: ~HSYNC_POL, vs: ~VSYNC_POL, sof: 1'b0, eol: 1'b0};
  if (H_TOTAL - 1 >= (1 << CNT_W) || V_TOTAL - 1 >= (1 << CNT_W)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_lat_chk
    $error("PIPE_LAT must be within 0..15");
  end
  logic [CNT_W-1:0] h, v;
  px_t              cur, o;
  always_ff @(posedge pclk or negedge rstbtn_n)
    if (!rstbtn_n) begin
      h <= '0;
      v <= '0;
    end else if (restart) begin
      h <= '0;
      v <= '0;
    end else if (h == HT1) begin
      h <= '0;
      v <= (v == VT1) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  assign rd_en = rstbtn_n & ~restart & (h < HA) & (v < VA);
  always_comb
    cur = '{h: h, v: v, de: rd_en, hb: h >= HA, vb: v >= VA,
            hs: (h >= HS0 && h < HS1) ? HSYNC_POL : ~HSYNC_POL,
            vs: (v >= VS0 && v < VS1) ? VSYNC_POL : ~VSYNC_POL,
            sof: h == '0 && v == '0, eol: h == HE && v < VA};
  if (PIPE_LAT == 0) begin : g_nolat
    assign o = (rstbtn_n & ~restart) ? cur : BLANK;
  end else begin : g_pipe
    px_t pipe [PIPE_LAT];
    // restart empties the whole delay line so stale active pixels never leak out
    always_ff @(posedge pclk or negedge rstbtn_n)
      if (!rstbtn_n) begin
        for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= BLANK;
      end else if (restart) begin
        for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= BLANK;
      end else begin
        pipe[0] <= cur;
        for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
      end
    assign o = pipe[PIPE_LAT-1];
  end
  assign hcount = o.h;
  assign vcount = o.v;
  assign de     = o.de;
  assign hblnk  = o.hb;
  assign vblnk  = o.vb;
  assign hsync  = o.hs;
  assign vsync  = o.vs;
  assign sof    = o.sof;
  assign eol    = o.eol;
`ifdef VTG_UNDERFLOW_EN
  always_ff @(posedge pclk or negedge rstbtn_n)
    if (!rstbtn_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (restart) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (rd_en & fifo_empty) begin
      underflow     <= 1'b1;
      underflow_cnt <= (&underflow_cnt) ? underflow_cnt : underflow_cnt + 16'd1;
    end
`else
  logic unused_fifo_empty;
  assign unused_fifo_empty = fifo_empty;
  assign underflow         = 1'b0;
  assign underflow_cnt     = '0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: frame-position model plus directed checks for video_timing_gen (8x6 raster, PIPE_LAT 2).
module tb_video_timing_gen;
  localparam int LAT = 2;
`ifdef VTG_UNDERFLOW_EN
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif
  logic        pclk = 1'b0, rstbtn_n = 1'b0, restart = 1'b0, fifo_empty = 1'b0;
  logic        rd_en, hsync, vsync, hblnk, vblnk, de, sof, eol, underflow;
  logic [10:0] hcount, vcount;
  logic [15:0] underflow_cnt;
  int          checks = 0, errors = 0;
  int          n = 0, ucnt = 0;
  bit          uflag = 1'b0, chk_en = 1'b0;
  always #5 pclk = ~pclk;
  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_LAT(LAT), .CNT_W(11)
  ) dut (
    .pclk(pclk), .rstbtn_n(rstbtn_n), .restart(restart), .fifo_empty(fifo_empty),
    .rd_en(rd_en), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .de(de), .sof(sof), .eol(eol),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit live(int k);
    return (k % 8 < 4) && ((k / 8) % 6 < 3);
  endfunction
  // n = cycles elapsed since the last reset release or restart release
  always @(posedge pclk or negedge rstbtn_n)
    if (!rstbtn_n) begin
      n <= 0;
      ucnt <= 0;
      uflag <= 1'b0;
    end else if (restart) begin
      n <= 0;
      ucnt <= 0;
      uflag <= 1'b0;
    end else begin
      n <= n + 1;
      if (UF && live(n) && fifo_empty) begin
        uflag <= 1'b1;
        if (ucnt < 65535) ucnt <= ucnt + 1;
      end
    end
  always @(negedge pclk)
    if (chk_en) begin
      bit blank;
      int p, hc, vc;
      blank = !rstbtn_n || n < LAT;
      p  = n - LAT;
      hc = blank ? 0 : p % 8;
      vc = blank ? 0 : (p / 8) % 6;
      check("rd_en", 64'(rd_en), 64'(rstbtn_n && !restart && live(n)));
      check("hcount", 64'(hcount), 64'(hc));
      check("vcount", 64'(vcount), 64'(vc));
      check("de", 64'(de), 64'(!blank && hc < 4 && vc < 3));
      check("hblnk", 64'(hblnk), 64'(blank || hc >= 4));
      check("vblnk", 64'(vblnk), 64'(blank || vc >= 3));
      check("hsync", 64'(hsync), 64'(blank || !(hc >= 5 && hc < 7)));
      check("vsync", 64'(vsync), 64'(blank || vc != 4));
      check("sof", 64'(sof), 64'(!blank && hc == 0 && vc == 0));
      check("eol", 64'(eol), 64'(!blank && hc == 3 && vc < 3));
      check("underflow", 64'(underflow), 64'(uflag));
      check("underflow_cnt", 64'(underflow_cnt), 64'(ucnt));
    end
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  initial begin
    logic [47:0] rdm, dem, sofm, eolm;
    logic [7:0]  hs_set, vs_set;
    int          sof2_k, wrapv, prevv;
    rdm = '0; dem = '0; sofm = '0; eolm = '0; hs_set = '0; vs_set = '0;
    sof2_k = -1; wrapv = -1; prevv = 0;
    chk_en = 1'b1;
    @(negedge pclk);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_hblnk", 64'(hblnk), 64'd1);
    check("rst_vsync", 64'(vsync), 64'd1);
    check("rst_ucnt", 64'(underflow_cnt), 64'd0);
    step();
    step();
    rstbtn_n = 1'b1;
    for (int k = 0; k < 56; k++) begin
      @(negedge pclk);
      if (k < 48) begin
        rdm[k] = rd_en; dem[k] = de; sofm[k] = sof; eolm[k] = eol;
      end
      if (k >= 2 && k < 50) begin
        if (!hsync) hs_set[hcount[2:0]] = 1'b1;
        if (!vsync) vs_set[vcount[2:0]] = 1'b1;
      end
      if (sof && k > 2) begin
        sof2_k = k;
        wrapv = prevv;
      end
      prevv = int'(vcount);
    end
    check("rd_en_cycles", 64'(rdm), 64'h0000_000F_0F0F);
    check("de_cycles", 64'(dem), 64'h0000_003C_3C3C);
    check("sof_cycles", 64'(sofm), 64'h0000_0000_0004);
    check("eol_cycles", 64'(eolm), 64'h0000_0020_2020);
    check("hsync_low_hcounts", 64'(hs_set), 64'h60);
    check("vsync_low_vcounts", 64'(vs_set), 64'h10);
    check("second_sof_cycle", 64'(sof2_k), 64'd50);
    check("vcount_before_wrap", 64'(wrapv), 64'd5);
    // cycle 58 is lead position (2,1)
    repeat (3) step();
    restart = 1'b1;
    @(negedge pclk);
    check("restart_cycle_rd_en", 64'(rd_en), 64'd0);
    step();
    restart = 1'b0;
    @(negedge pclk);
    check("post_restart_rd_en", 64'(rd_en), 64'd1);
    check("post_restart_de0", 64'(de), 64'd0);
    @(negedge pclk);
    check("post_restart_de1", 64'(de), 64'd0);
    check("post_restart_sof_early", 64'(sof), 64'd0);
    @(negedge pclk);
    check("post_restart_sof", 64'(sof), 64'd1);
    check("post_restart_de2", 64'(de), 64'd1);
    step();
    restart = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check("held_restart_rd_en", 64'(rd_en), 64'd0);
    end
    step();
    restart = 1'b0;
    @(negedge pclk);
    check("held_release_rd_en", 64'(rd_en), 64'd1);
    fifo_empty = 1'b1;
    step();
    step();
    step();
    fifo_empty = 1'b0;
    @(negedge pclk);
    check("underflow_set", 64'(underflow), UF ? 64'd1 : 64'd0);
    check("underflow_cnt3", 64'(underflow_cnt), UF ? 64'd3 : 64'd0);
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    @(negedge pclk);
    check("underflow_cleared", 64'(underflow), 64'd0);
    check("underflow_cnt_cleared", 64'(underflow_cnt), 64'd0);
    repeat (4) step();
    fifo_empty = 1'b1;
    repeat (4) step();
    fifo_empty = 1'b0;
    @(negedge pclk);
    check("blank_empty_ignored", 64'(underflow_cnt), 64'd0);
    repeat (3) step();
    check("pre_reset_de", 64'(de), 64'd1);
    check("pre_reset_hcount", 64'(hcount), 64'd1);
    #2 rstbtn_n = 1'b0;
    #1;
    check("async_rd_en", 64'(rd_en), 64'd0);
    check("async_de", 64'(de), 64'd0);
    check("async_hcount", 64'(hcount), 64'd0);
    check("async_vcount", 64'(vcount), 64'd0);
    check("async_hblnk", 64'(hblnk), 64'd1);
    check("async_vblnk", 64'(vblnk), 64'd1);
    check("async_hsync", 64'(hsync), 64'd1);
    check("async_sof", 64'(sof), 64'd0);
    step();
    step();
    rstbtn_n = 1'b1;
    @(negedge pclk);
    check("rerun_rd_en", 64'(rd_en), 64'd1);
    check("rerun_de0", 64'(de), 64'd0);
    @(negedge pclk);
    check("rerun_de1", 64'(de), 64'd0);
    @(negedge pclk);
    check("rerun_de2", 64'(de), 64'd1);
    check("rerun_sof", 64'(sof), 64'd1);
    repeat (10) @(negedge pclk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE 640: live pixels per line
- H_FP 16: h front porch
- H_SYNC 96: hsync width
- H_BP 48: h back porch
- V_ACTIVE 480: live lines
- V_FP 11: v front porch
- V_SYNC 2: vsync width
- V_BP 31: v back porch
- HSYNC_POL 0: hsync asserted level
- VSYNC_POL 0: vsync asserted level
- PIPE_LAT 2: rd_en lead over de, range 0..15
- CNT_W 11: counter width

REQ-002 Ports SHALL be (name, direction, width, meaning):
- pclk  in  1  pixel clock (the only clock)
- rstbtn_n  in  1  reset, asynchronous, active-low
- restart  in  1  synchronous frame restart
- fifo_empty  in  1  pixel FIFO empty flag
- rd_en  out  1  pixel FIFO read request
- hcount  out  CNT_W  pixel position
- vcount  out  CNT_W  line position
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- de  out  1  data enable
- sof  out  1  start-of-frame pulse
- eol  out  1  end-of-active-line pulse
- underflow  out  1  sticky read-while-empty flag
- underflow_cnt  out  16  underflow event count

Function
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP; CNT_W SHALL hold H_TOTAL-1 and V_TOTAL-1, checked at elaboration.
REQ-004 The lead counter h SHALL count 0..H_TOTAL-1 and wrap to 0; v SHALL increment on each h wrap and wrap to 0 after V_TOTAL-1.
REQ-005 At lead position (h,v), rd_en SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-006 All other outputs except underflow/underflow_cnt SHALL be registered and delayed exactly PIPE_LAT cycles from lead position; with PIPE_LAT=0 they SHALL be cycle-aligned with rd_en.
REQ-007 For each delayed position (hcount,vcount), the outputs SHALL be:
- de = rd_en of that position
- hblnk = hcount>=H_ACTIVE
- vblnk = vcount>=V_ACTIVE
- hsync = HSYNC_POL when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HSYNC_POL
- vsync = VSYNC_POL when vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~VSYNC_POL
REQ-008 sof SHALL pulse one cycle at hcount=0,vcount=0; eol SHALL pulse one cycle at hcount=H_ACTIVE-1 when vcount<V_ACTIVE.
REQ-009 Invariant: rd_en high in cycle t iff de high in cycle t+PIPE_LAT, including across line and frame wrap.
REQ-010 restart=1 SHALL set the lead counter to (0,0) on the next edge and flush the delay line to the blank state defined in REQ-012.
REQ-011 restart held high SHALL keep the lead counter at (0,0) and rd_en low; counting SHALL resume on the first edge after release.

Reset
REQ-012 While rstbtn_n=0, the SHALL state is:
- lead counter (0,0); rd_en=0
- delay line blank: hcount=0, vcount=0, de=0, hblnk=1, vblnk=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, sof=0, eol=0
- underflow=0, underflow_cnt=0
REQ-013 After reset release, the first rd_en SHALL be the first cycle, and the first de SHALL follow PIPE_LAT cycles later.

Configuration
REQ-014 Macro VTG_UNDERFLOW_EN SHALL compile underflow detection in or out.
REQ-015 With VTG_UNDERFLOW_EN defined, an underflow event SHALL be rd_en=1 with fifo_empty=1 in the same cycle, with these effects one cycle later:
- underflow set and held until reset or restart
- underflow_cnt incremented, saturating at 16'hFFFF
REQ-016 Without VTG_UNDERFLOW_EN, underflow and underflow_cnt SHALL be constant 0, fifo_empty SHALL be ignored, and all ports SHALL remain present.

Verification
Bench parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), PIPE_LAT=2, POL=0.
REQ-017 Reset release, free-run 48 cycles -> rd_en high at cycles 0-3, 8-11, 16-19; de high at 2-5, 10-13, 18-21; sof at cycle 2; eol at 5, 13, 21.
REQ-018 Free-run one full frame -> hsync low at hcount 5-6 only; vsync low for vcount=4 only; vcount wraps 5->0 at the next sof.
REQ-019 restart pulsed at lead position (2,1) -> next cycle rd_en=1 at (0,0); de=0 for the following 2 cycles; sof appears 2 cycles after restart release.
REQ-020 With VTG_UNDERFLOW_EN, fifo_empty=1 across 3 active rd_en cycles -> underflow=1 and underflow_cnt=3; restart clears both to 0; with the macro undefined, both stay 0.
REQ-021 rstbtn_n pulsed low mid-line, asynchronously between edges -> outputs immediately take the REQ-012 values; timing restarts per REQ-013.
